// File: rtl/slice_scheduler_pkg.sv
// Shared types for the slice scheduler: FSM states, descriptor bundle
// and the block-count clamp used when a descriptor is accepted.
package prores_enc_pkg;

    localparam int unsigned MAX_SLICE_BLOCKS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } slice_sched_state_t;

    typedef struct packed {
        logic [31:0] block_num;
        logic [31:0] offset;
        logic [31:0] qscale;
    } slice_desc_t;

    // A zero-block slice still runs one block; oversize requests are capped.
    function automatic logic [31:0] clamp_blocks(
        input logic [31:0] n,
        input logic [31:0] max_n
    );
        if (n == 32'd0) begin
            return 32'd1;
        end
        if (n > max_n) begin
            return max_n;
        end
        return n;
    endfunction

endpackage

// File: rtl/slice_scheduler_if.sv
// Descriptor handshake, datapath control/strobes and slice result bundle.
// master = descriptor source and datapath, slave = scheduler.
interface slice_scheduler_if;

    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_block_num;
    logic [31:0] desc_offset;
    logic [31:0] desc_qscale;

    logic        component_reset_n;
    logic [31:0] slice_sequencer_block_num;
    logic [31:0] slice_sequencer_offset;
    logic [31:0] qscale;

    logic        sb_enable;
    logic [63:0] sb_size_of_bit;
    logic        sb_flush;

    logic        slice_done;
    logic        slice_error;
    logic [31:0] slice_bits;
    logic [31:0] slice_bytes;
    logic        busy;

    modport master (
        output desc_valid,
        output desc_block_num,
        output desc_offset,
        output desc_qscale,
        output sb_enable,
        output sb_size_of_bit,
        output sb_flush,
        input  desc_ready,
        input  component_reset_n,
        input  slice_sequencer_block_num,
        input  slice_sequencer_offset,
        input  qscale,
        input  slice_done,
        input  slice_error,
        input  slice_bits,
        input  slice_bytes,
        input  busy
    );

    modport slave (
        input  desc_valid,
        input  desc_block_num,
        input  desc_offset,
        input  desc_qscale,
        input  sb_enable,
        input  sb_size_of_bit,
        input  sb_flush,
        output desc_ready,
        output component_reset_n,
        output slice_sequencer_block_num,
        output slice_sequencer_offset,
        output qscale,
        output slice_done,
        output slice_error,
        output slice_bits,
        output slice_bytes,
        output busy
    );

endinterface

// File: rtl/slice_scheduler_bit_accum.sv
// Saturating 32-bit bit-count accumulator. sum_next is the value the
// register takes at the next edge, so a final strobe can be captured with it.
module slice_bit_accum (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] add_value,
    output logic [31:0] sum_next
);

    logic [31:0] sum;
    logic [32:0] raw;

    // Clear wins over enable; a carry out pins the total at all-ones.
    always_comb begin
        raw      = {1'b0, sum} + {1'b0, add_value};
        sum_next = sum;
        if (clear) begin
            sum_next = '0;
        end else if (enable) begin
            sum_next = raw[32] ? '1 : raw[31:0];
        end
    end

    // Running total register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else begin
            sum <= sum_next;
        end
    end

endmodule

// File: rtl/slice_scheduler.sv
// Runs the slice encoding datapath one slice at a time: datapath reset
// pulse, configuration, bit counting until flush or timeout, size report.
module slice_scheduler
    import prores_enc_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned MAX_BLOCKS = MAX_SLICE_BLOCKS
) (
    input logic              clock,
    input logic              reset,
    slice_scheduler_if.slave bus
);

    localparam logic [31:0] RST_LOAD     = 32'(RST_CYCLES);
    localparam logic [31:0] MAX_BN       = 32'(MAX_BLOCKS);
    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST =
        TIMEOUT_EN ? 32'(TIMEOUT - 1) : 32'd0;

    slice_sched_state_t state;
    slice_sched_state_t next_state;
    slice_desc_t        cfg;

    logic [31:0] rst_cnt;
    logic [31:0] run_cnt;
    logic [31:0] acc_next;

    logic accept;
    logic in_run;
    logic flush;
    logic timeout_hit;
    logic acc_en;
    logic done_next;

    logic        done_q;
    logic        error_q;
    logic [31:0] bits_q;
    logic [31:0] bytes_q;

    logic unused_hi;

    // Strobes only count while the datapath is out of reset.
    always_comb begin
        accept      = (state == S_IDLE) && bus.desc_valid;
        in_run      = (state == S_RUN);
        flush       = in_run && bus.sb_flush;
        timeout_hit = TIMEOUT_EN && in_run && (run_cnt == TIMEOUT_LAST);
        acc_en      = in_run && bus.sb_enable;
    end

    // Next state; done_next marks the RUN cycle that ends the slice.
    always_comb begin
        next_state = state;
        done_next  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = S_RESET;
                end
            end
            S_RESET: begin
                if (rst_cnt <= 32'd1) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (flush || timeout_hit) begin
                    next_state = S_DONE;
                    done_next  = 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath reset hold counter, loaded on accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_cnt <= '0;
        end else if (accept) begin
            rst_cnt <= RST_LOAD;
        end else if (state == S_RESET && rst_cnt != 32'd0) begin
            rst_cnt <= rst_cnt - 32'd1;
        end
    end

    // Cycles spent in RUN; zero on the first RUN cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (in_run) begin
            run_cnt <= run_cnt + 32'd1;
        end else begin
            run_cnt <= '0;
        end
    end

    // Slice configuration, held from accept to the next accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg <= '0;
        end else if (accept) begin
            cfg.block_num <= clamp_blocks(bus.desc_block_num, MAX_BN);
            cfg.offset    <= bus.desc_offset;
            cfg.qscale    <= bus.desc_qscale;
        end
    end

    slice_bit_accum u_accum (
        .clock     (clock),
        .reset     (reset),
        .clear     (accept),
        .enable    (acc_en),
        .add_value (bus.sb_size_of_bit[31:0]),
        .sum_next  (acc_next)
    );

    // Result registers, loaded as RUN ends so they are valid during DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            bits_q  <= '0;
            bytes_q <= '0;
        end else begin
            done_q  <= done_next;
            error_q <= done_next && timeout_hit && !flush;
            if (done_next) begin
                bits_q  <= acc_next;
                bytes_q <= 32'(({1'b0, acc_next} + 33'd7) >> 3);
            end
        end
    end

    assign unused_hi = ^bus.sb_size_of_bit[63:32];

    assign bus.desc_ready                = (state == S_IDLE);
    assign bus.busy                      = (state != S_IDLE);
    assign bus.component_reset_n         = in_run;
    assign bus.slice_sequencer_block_num = cfg.block_num;
    assign bus.slice_sequencer_offset    = cfg.offset;
    assign bus.qscale                    = cfg.qscale;
    assign bus.slice_done                = done_q;
    assign bus.slice_error               = error_q;
    assign bus.slice_bits                = bits_q;
    assign bus.slice_bytes               = bytes_q;

endmodule
